// File: rtl/ahblite_medfilter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ahblite_medfilter_ctrl
// Brief    : AHB-Lite register slave and raster frame sequencer for a 3x3
//            median filter core. Issues pixel reads, flags full windows,
//            honours core backpressure, drains the core pipeline, then
//            raises done and an optional level interrupt.
//            Optional cycle/stall counters: define MEDF_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ahblite_medfilter_ctrl #(
    parameter int PA_W     = 16,
    parameter int DIM_W    = 12,
    parameter int FILT_LAT = 4
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic [2:0]       HSIZE,
    input  logic [3:0]       HPROT,
    input  logic             HWRITE,
    input  logic [31:0]      HWDATA,
    input  logic             HREADY,
    output logic             HREADYOUT,
    output logic [31:0]      HRDATA,
    output logic             HRESP,
    output logic             pix_rd,
    output logic [PA_W-1:0]  pix_addr,
    output logic             filt_shift,
    output logic             filt_win_vld,
    input  logic             filt_ready,
    output logic             medf_irq
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // DRAIN covers one cycle of memory latency plus the core pipeline
    localparam logic [4:0] c_drain_last = 5'(FILT_LAT);

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_wr_pend;
    logic [2:0]         r_reg_sel;
    logic               r_irq_en;
    logic [DIM_W-1:0]   r_width;
    logic [DIM_W-1:0]   r_height;
    logic [PA_W-1:0]    r_base;
    logic               r_done;
    logic               r_err;

    logic [DIM_W-1:0]   r_fw;
    logic [DIM_W-1:0]   r_fh;
    logic [DIM_W-1:0]   r_row;
    logic [DIM_W-1:0]   r_col;
    logic [PA_W-1:0]    r_addr;
    logic [4:0]         r_drain_cnt;

    logic               w_wr;
    logic               w_wr_ctrl;
    logic               w_wr_status;
    logic               w_start;
    logic               w_abort;
    logic               w_size_ok;
    logic               w_last_pix;
    logic               w_busy;
    logic               w_accept;
    logic               w_err_set;
    logic               w_done_set;
    logic               w_issue;
    logic [31:0]        w_rdata;

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    // Register write strobes: address captured last cycle, data this cycle
    assign w_wr        = r_wr_pend & HREADY;
    assign w_wr_ctrl   = w_wr && (r_reg_sel == 3'd0);
    assign w_wr_status = w_wr && (r_reg_sel == 3'd3);
    assign w_abort     = w_wr_ctrl & HWDATA[2];
    assign w_start     = w_wr_ctrl & HWDATA[0] & ~HWDATA[2];

    assign w_size_ok  = (r_width >= DIM_W'(3)) && (r_height >= DIM_W'(3));
    assign w_last_pix = (r_row == r_fh - DIM_W'(1)) && (r_col == r_fw - DIM_W'(1));
    assign w_busy     = (r_state != S_IDLE);

    assign pix_rd   = w_issue;
    assign pix_addr = r_addr;

    // Bus address phase capture (held while another slave stalls the bus)
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wr_pend <= 1'b0;
            r_reg_sel <= 3'd0;
        end else if (HREADY) begin
            r_wr_pend <= HSEL & HTRANS[1] & HWRITE;
            r_reg_sel <= HADDR[4:2];
        end
    end

    // Programmable configuration registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_irq_en <= 1'b0;
            r_width  <= '0;
            r_height <= '0;
            r_base   <= '0;
        end else if (w_wr) begin
            case (r_reg_sel)
                3'd0: r_irq_en <= HWDATA[1];
                3'd1: begin
                    r_width  <= HWDATA[DIM_W-1:0];
                    r_height <= HWDATA[16+DIM_W-1:16];
                end
                3'd2: r_base <= HWDATA[PA_W-1:0];
                default: ;
            endcase
        end
    end

    // Sticky status flags: hardware set takes priority over W1C
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            medf_irq <= 1'b0;
        end else begin
            if (w_done_set)
                r_done <= 1'b1;
            else if (w_wr_status && HWDATA[1])
                r_done <= 1'b0;
            if (w_err_set)
                r_err <= 1'b1;
            else if (w_wr_status && HWDATA[2])
                r_err <= 1'b0;
            medf_irq <= r_irq_en & (r_done | r_err);
        end
    end

    // FSM state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM next state and per-cycle control; abort overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_err_set   = 1'b0;
        w_done_set  = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (w_size_ok) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (filt_ready) begin
                    w_issue = 1'b1;
                    if (w_last_pix)
                        w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == c_drain_last)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done_set  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt = S_IDLE;
            w_accept    = 1'b0;
            w_err_set   = 1'b0;
            w_done_set  = 1'b0;
            w_issue     = 1'b0;
        end
    end

    // Raster counters, read address and drain timer
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_fw        <= '0;
            r_fh        <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_addr      <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_fw   <= r_width;
                r_fh   <= r_height;
                r_row  <= '0;
                r_col  <= '0;
                r_addr <= r_base;
            end else if (w_issue) begin
                r_addr <= r_addr + PA_W'(1);
                if (r_col == r_fw - DIM_W'(1)) begin
                    r_col <= '0;
                    r_row <= r_row + DIM_W'(1);
                end else begin
                    r_col <= r_col + DIM_W'(1);
                end
            end
            if (r_state == S_DRAIN)
                r_drain_cnt <= r_drain_cnt + 5'd1;
            else
                r_drain_cnt <= '0;
        end
    end

    // Core strobes follow the read by one cycle, matching memory latency
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            filt_shift   <= 1'b0;
            filt_win_vld <= 1'b0;
        end else begin
            filt_shift   <= w_issue;
            filt_win_vld <= w_issue && (r_row >= DIM_W'(2)) && (r_col >= DIM_W'(2));
        end
    end

`ifdef MEDF_CTRL_PERF_EN
    logic [31:0] r_cycles;
    logic [31:0] r_stalls;

    // Saturating busy-cycle and backpressure-stall counters
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_cycles <= '0;
            r_stalls <= '0;
        end else if (w_accept) begin
            r_cycles <= '0;
            r_stalls <= '0;
        end else begin
            if (w_busy && (r_cycles != 32'hFFFF_FFFF))
                r_cycles <= r_cycles + 32'd1;
            if ((r_state == S_RUN) && !filt_ready && (r_stalls != 32'hFFFF_FFFF))
                r_stalls <= r_stalls + 32'd1;
        end
    end
`endif

    // Read data decode from the registered address
    always_comb begin
        w_rdata = '0;
        case (r_reg_sel)
            3'd0: w_rdata[1] = r_irq_en;
            3'd1: begin
                w_rdata[DIM_W-1:0]     = r_width;
                w_rdata[16+DIM_W-1:16] = r_height;
            end
            3'd2: w_rdata[PA_W-1:0] = r_base;
            3'd3: w_rdata[2:0] = {r_err, r_done, w_busy};
`ifdef MEDF_CTRL_PERF_EN
            3'd4: w_rdata = r_cycles;
            3'd5: w_rdata = r_stalls;
`endif
            default: ;
        endcase
    end

    assign HRDATA = w_rdata;

    // Bus fields this slave does not decode
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, HADDR[31:5], HADDR[1:0], HTRANS[0], HSIZE, HPROT, HWDATA};

endmodule
`default_nettype wire

// File: tb/tb_ahblite_medfilter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahblite_medfilter_ctrl
// Brief    : Self-checking bench for ahblite_medfilter_ctrl. Frames are
//            checked against a raster model of addresses and window flags.
//            Counter checks track MEDF_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahblite_medfilter_ctrl;

    localparam int PA_W     = 16;
    localparam int DIM_W    = 12;
    localparam int FILT_LAT = 4;

    logic              HCLK = 1'b0;
    logic              HRESETn = 1'b0;
    logic              HSEL = 1'b0;
    logic [31:0]       HADDR = '0;
    logic [1:0]        HTRANS = 2'b00;
    logic [2:0]        HSIZE = 3'b010;
    logic [3:0]        HPROT = 4'b0011;
    logic              HWRITE = 1'b0;
    logic [31:0]       HWDATA = '0;
    logic              HREADY = 1'b1;
    logic              HREADYOUT;
    logic [31:0]       HRDATA;
    logic              HRESP;
    logic              pix_rd;
    logic [PA_W-1:0]   pix_addr;
    logic              filt_shift;
    logic              filt_win_vld;
    logic              filt_ready = 1'b1;
    logic              medf_irq;

    int n_checks = 0;
    int n_err    = 0;

    ahblite_medfilter_ctrl #(.PA_W(PA_W), .DIM_W(DIM_W), .FILT_LAT(FILT_LAT)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .HRESP(HRESP), .pix_rd(pix_rd), .pix_addr(pix_addr),
        .filt_shift(filt_shift), .filt_win_vld(filt_win_vld),
        .filt_ready(filt_ready), .medf_irq(medf_irq)
    );

    always #5 HCLK = ~HCLK;

    // Backpressure driver: random or directed, changed just after the edge
    bit rand_stall = 1'b0;
    bit fr_manual  = 1'b1;
    always @(posedge HCLK) begin
        #1;
        filt_ready = rand_stall ? ($urandom_range(0, 3) != 0) : fr_manual;
    end

    // Monitor: logs every read address and every core beat's window flag
    int              cyc = 0;
    int              last_rd_cyc = 0;
    int              stall_viol = 0;
    logic [PA_W-1:0] q_addr[$];
    bit              q_win[$];
    always @(negedge HCLK) begin
        cyc = cyc + 1;
        if (pix_rd) begin
            q_addr.push_back(pix_addr);
            last_rd_cyc = cyc;
        end
        if (filt_shift)
            q_win.push_back(filt_win_vld);
        if (pix_rd && !filt_ready)
            stall_viol = stall_viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        ahb_read(a, d);
        check(tag, d, exp);
    endtask

    // Run one frame and compare it against the raster model.
    // kind: 0 = no stall, 1 = 3-cycle stall after 6 pixels, 2 = random stalls
    task automatic run_frame(input string tag, input int w, input int h,
                             input int base, input int kind);
        int s0, w0, v0, nbad, irq_cyc, n;
        bit got_irq;
        s0 = q_addr.size();
        w0 = q_win.size();
        v0 = stall_viol;
        ahb_write(32'h04, (h << 16) | w);
        ahb_write(32'h08, base);
        fr_manual  = 1'b1;
        rand_stall = (kind == 2);
        ahb_write(32'h00, 32'h3);
        if (kind == 1) begin
            n = 0;
            while ((q_addr.size() - s0) < 6 && n < 200) begin
                @(negedge HCLK); #1; n++;
            end
            fr_manual = 1'b0;
            repeat (3) @(negedge HCLK);
            #1 fr_manual = 1'b1;
        end
        got_irq = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge HCLK); #1;
            if (medf_irq) begin got_irq = 1'b1; break; end
        end
        irq_cyc    = cyc;
        rand_stall = 1'b0;
        check({tag, "_irq_seen"}, 32'(got_irq), 32'd1);
        check({tag, "_pix_count"}, q_addr.size() - s0, w * h);
        nbad = 0;
        for (int i = 0; i < w * h && (s0 + i) < q_addr.size(); i++)
            if (q_addr[s0 + i] !== PA_W'((base + i) % (1 << PA_W))) nbad++;
        check({tag, "_addr_seq_bad"}, nbad, 0);
        check({tag, "_shift_count"}, q_win.size() - w0, w * h);
        nbad = 0;
        for (int i = 0; i < w * h && (w0 + i) < q_win.size(); i++)
            if (q_win[w0 + i] !== (((i / w) >= 2) && ((i % w) >= 2))) nbad++;
        check({tag, "_win_flags_bad"}, nbad, 0);
        check({tag, "_stall_viol"}, stall_viol - v0, 0);
        check({tag, "_irq_latency_ok"},
              32'((irq_cyc - last_rd_cyc) >= FILT_LAT + 1 && (irq_cyc - last_rd_cyc) <= FILT_LAT + 4),
              32'd1);
        read_check({tag, "_status_done"}, 32'h0C, 32'h2);
    endtask

    task automatic clear_done(input string tag);
        ahb_write(32'h0C, 32'h2);
        read_check({tag, "_status_clr"}, 32'h0C, 32'h0);
        repeat (2) @(negedge HCLK);
        #1 check({tag, "_irq_clr"}, 32'(medf_irq), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, n, w, h, b;

        // Reset state
        repeat (3) @(negedge HCLK);
        check("rst_pix_rd", 32'(pix_rd), 32'd0);
        check("rst_irq", 32'(medf_irq), 32'd0);
        check("rst_filt_shift", 32'(filt_shift), 32'd0);
        HRESETn = 1'b1;
        read_check("rst_ctrl",   32'h00, 32'h0);
        read_check("rst_size",   32'h04, 32'h0);
        read_check("rst_base",   32'h08, 32'h0);
        read_check("rst_status", 32'h0C, 32'h0);
        check("rst_irq_after", 32'(medf_irq), 32'd0);
        check("rst_pix_rd_after", 32'(pix_rd), 32'd0);

        // Nominal 4x4 frame
        run_frame("f4x4", 4, 4, 32'h0100, 0);
        check("f4x4_irq", 32'(medf_irq), 32'd1);
        read_check("ctrl_rd", 32'h00, 32'h2);
        read_check("size_rd", 32'h04, 32'h0004_0004);
        clear_done("f4x4");

        // Same frame with a 3-cycle mid-row stall
        run_frame("stall", 4, 4, 32'h0100, 1);
`ifdef MEDF_CTRL_PERF_EN
        read_check("perf_cycles", 32'h10, 32'(16 + 3 + FILT_LAT + 1 + 1));
        read_check("perf_stalls", 32'h14, 32'd3);
`else
        read_check("no_perf_10", 32'h10, 32'h0);
        read_check("no_perf_14", 32'h14, 32'h0);
`endif
        read_check("undecoded_18", 32'h18, 32'h0);
        clear_done("stall");

        // Undersized frame sets err and issues nothing
        ahb_write(32'h04, 32'h0002_0008);
        s0 = q_addr.size();
        ahb_write(32'h00, 32'h3);
        repeat (4) @(negedge HCLK);
        read_check("err_status", 32'h0C, 32'h4);
        check("err_pix_count", q_addr.size() - s0, 0);
        #1 check("err_irq", 32'(medf_irq), 32'd1);
        ahb_write(32'h0C, 32'h4);
        read_check("err_clr", 32'h0C, 32'h0);
        repeat (2) @(negedge HCLK);
        #1 check("err_irq_clr", 32'(medf_irq), 32'd0);

        // Abort after 5 pixels, then replay from BASE
        ahb_write(32'h04, 32'h0004_0004);
        ahb_write(32'h08, 32'h0100);
        fr_manual = 1'b1;
        s0 = q_addr.size();
        ahb_write(32'h00, 32'h3);
        n = 0;
        while ((q_addr.size() - s0) < 5 && n < 200) begin
            @(negedge HCLK); #1; n++;
        end
        fr_manual = 1'b0;
        ahb_write(32'h00, 32'h6);
        read_check("abort_status", 32'h0C, 32'h0);
        check("abort_pix_count", q_addr.size() - s0, 5);
        fr_manual = 1'b1;
        repeat (20) @(negedge HCLK);
        check("abort_no_more_pix", q_addr.size() - s0, 5);
        read_check("abort_status_late", 32'h0C, 32'h0);
        run_frame("replay", 4, 4, 32'h0100, 0);
        clear_done("replay");

        // Randomized frames with random backpressure, one near address wrap
        for (int k = 0; k < 3; k++) begin
            w = $urandom_range(3, 6);
            h = $urandom_range(3, 6);
            b = (k == 0) ? 32'hFFF8 : $urandom_range(0, 32'hFFFF);
            run_frame($sformatf("rnd%0d", k), w, h, b, 2);
            clear_done($sformatf("rnd%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
